// File: rtl/ahb_lite_resp_mux.sv
// AHB-Lite response multiplexer: routes the data phase of NUM_SLAVES slaves back to the master and
// contains a default slave for ERROR responses. Define AHB_RESP_MUX_TIMEOUT_EN for the wait-state timeout.
module ahb_lite_resp_mux #(
   parameter int unsigned NUM_SLAVES     = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                             HCLK,
   input  logic                             HRESETn,
   input  logic [NUM_SLAVES-1:0]            HSEL,
   input  logic [1:0]                       HTRANS,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]            HRESP_S,
   output logic [DATA_WIDTH-1:0]            HRDATA,
   output logic                             HREADY,
   output logic                             HRESP,
   output logic                             TIMEOUT
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
      $error("ahb_lite_resp_mux: NUM_SLAVES must be 1..16");
   end
   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("ahb_lite_resp_mux: DATA_WIDTH must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("ahb_lite_resp_mux: TIMEOUT_CYCLES must be 2..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ERR1 = 2'd1,
      ERR2 = 2'd2
   } def_state_e;

   localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

   logic [NUM_SLAVES-1:0] sel_q;
   logic                  def_q;
   def_state_e            state_q;
   def_state_e            state_d;
   logic                  sel_onehot;
   logic                  cap_def;
   logic                  timeout_hit;
   logic [DATA_WIDTH-1:0] route_data;
   logic                  route_ready;
   logic                  route_resp;
   logic                  unused_htrans;

   // Only HTRANS[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
   assign unused_htrans = HTRANS[0];

   assign sel_onehot = (HSEL != '0) && ((HSEL & (HSEL - SEL_ONE)) == '0);
   assign cap_def    = HTRANS[1] && !sel_onehot;

   // AND-OR mux; sel_q is one-hot or zero, so at most one slave contributes.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      route_data  = '0;
      route_ready = 1'b0;
      route_resp  = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            route_data  = route_data | HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
            route_ready = route_ready | HREADYOUT_S[i];
            route_resp  = route_resp | HRESP_S[i];
         end
      end
   end

   // def_q is set for exactly the ERR1/ERR2 cycles; the FSM only tells them apart.
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (def_q) begin
         HRESP  = 1'b1;
         HREADY = (state_q == ERR2);
      end else if (sel_q != '0) begin
         HRDATA = route_data;
         HREADY = route_ready;
         HRESP  = route_resp;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if ((HREADY && cap_def) || timeout_hit) state_d = ERR1;
         ERR1:    state_d = ERR2;
         ERR2:    state_d = cap_def ? ERR1 : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q   <= '0;
         def_q   <= 1'b0;
         state_q <= IDLE;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         if (HREADY) begin
            sel_q <= (HTRANS[1] && sel_onehot) ? HSEL : '0;
            def_q <= cap_def;
         end else if (timeout_hit) begin
            sel_q <= '0;
            def_q <= 1'b1;
         end
      end
   end

`ifdef AHB_RESP_MUX_TIMEOUT_EN
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_q;
   logic        timeout_q;
   logic        slave_stall;

   // A stalled routed slave is the only source of HREADY = 0 outside the default sequence.
   assign slave_stall = (sel_q != '0) && !route_ready;
   assign timeout_hit = slave_stall && (wait_q == WAIT_LAST);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
         if (HREADY) begin
            wait_q <= '0;
         end else if (slave_stall) begin
            wait_q <= wait_q + 16'd1;
         end
      end
   end

   assign TIMEOUT = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign TIMEOUT     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_lite_resp_mux.sv
// Self-checking bench for ahb_lite_resp_mux: directed sequences plus random traffic against a
// transaction-level model of the data phase (current target, wait count, default-response step).
module tb_ahb_lite_resp_mux;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int TO = 4;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_NONSEQ = 2'b10;

   logic             HCLK = 1'b0;
   logic             HRESETn = 1'b0;
   logic [NS-1:0]    HSEL = '0;
   logic [1:0]       HTRANS = T_IDLE;
   logic [NS*DW-1:0] HRDATA_S = '0;
   logic [NS-1:0]    HREADYOUT_S = '1;
   logic [NS-1:0]    HRESP_S = '0;
   logic [DW-1:0]    HRDATA;
   logic             HREADY;
   logic             HRESP;
   logic             TIMEOUT;

   ahb_lite_resp_mux #(
      .NUM_SLAVES    (NS),
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HSEL       (HSEL),
      .HTRANS     (HTRANS),
      .HRDATA_S   (HRDATA_S),
      .HREADYOUT_S(HREADYOUT_S),
      .HRESP_S    (HRESP_S),
      .HRDATA     (HRDATA),
      .HREADY     (HREADY),
      .HRESP      (HRESP),
      .TIMEOUT    (TIMEOUT)
   );

   always #5 HCLK = ~HCLK;

   // Model: what the outstanding data phase is, rather than how the RTL encodes it.
   typedef enum {PH_NONE, PH_SLAVE, PH_DEF} phase_e;

   phase_e        ph = PH_NONE;
   int            slv = 0;
   int            err_idx = 0;
   int            waits = 0;
   bit            exp_to = 1'b0;
   logic          e_rdy;
   logic          e_resp;
   logic [DW-1:0] e_data;

   int tests_run = 0;
   int failed = 0;

   task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      assert (got === exp) else begin
         failed++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_expect();
      e_rdy  = 1'b1;
      e_resp = 1'b0;
      e_data = '0;
      case (ph)
         PH_SLAVE: begin
            e_rdy  = HREADYOUT_S[slv];
            e_resp = HRESP_S[slv];
            e_data = HRDATA_S[slv*DW +: DW];
         end
         PH_DEF: begin
            e_rdy  = (err_idx == 1);
            e_resp = 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic model_clock();
      bit to_now = 1'b0;
      if (e_rdy) begin
         waits = 0;
         if (!HTRANS[1]) begin
            ph = PH_NONE;
         end else if ($countones(HSEL) == 1) begin
            ph = PH_SLAVE;
            for (int i = 0; i < NS; i++) if (HSEL[i]) slv = i;
         end else begin
            ph      = PH_DEF;
            err_idx = 0;
         end
      end else if (ph == PH_DEF) begin
         err_idx = 1;
      end else if (ph == PH_SLAVE) begin
         waits++;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
         if (waits == TO) begin
            ph      = PH_DEF;
            err_idx = 0;
            to_now  = 1'b1;
         end
`endif
      end
      exp_to = to_now;
   endtask

   task automatic step(input string tag, input logic [NS-1:0] sel, input logic [1:0] tr,
                       input logic [NS-1:0] rdy, input logic [NS-1:0] rsp);
      @(negedge HCLK);
      HSEL        = sel;
      HTRANS      = tr;
      HREADYOUT_S = rdy;
      HRESP_S     = rsp;
      #2;
      model_expect();
      cmp({tag, ".hready"}, 64'(HREADY), 64'(e_rdy));
      cmp({tag, ".hresp"}, 64'(HRESP), 64'(e_resp));
      cmp({tag, ".hrdata"}, 64'(HRDATA), 64'(e_data));
      cmp({tag, ".timeout"}, 64'(TIMEOUT), 64'(exp_to));
      @(posedge HCLK);
      model_clock();
   endtask

   task automatic check_reset_values(input string tag);
      cmp({tag, ".hready"}, 64'(HREADY), 64'd1);
      cmp({tag, ".hresp"}, 64'(HRESP), 64'd0);
      cmp({tag, ".hrdata"}, 64'(HRDATA), 64'd0);
      cmp({tag, ".timeout"}, 64'(TIMEOUT), 64'd0);
   endtask

   // Asserts reset between clock edges and checks outputs before any edge can occur.
   task automatic reset_mid_cycle(input string tag);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b0;
      #1;
      check_reset_values(tag);
      ph     = PH_NONE;
      waits  = 0;
      exp_to = 1'b0;
      HSEL   = '0;
      HTRANS = T_IDLE;
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   initial begin
      int            r;
      logic [NS-1:0] rsel;
      logic [NS-1:0] rrdy;
      logic [NS-1:0] rrsp;

      for (int i = 0; i < NS; i++) HRDATA_S[i*DW +: DW] = DW'(32'h1111_1111 * (i + 1));
      HRDATA_S[2*DW +: DW] = 32'hDEAD_BEEF;

      // 1. reset and idle bus
      #12;
      check_reset_values("reset_held");
      @(negedge HCLK);
      HRESETn = 1'b1;
      step("idle0", '0, T_IDLE, '1, '0);
      step("idle1", 4'b0100, T_IDLE, '1, '0);

      // 2. slave 2 with two wait states
      step("s2_addr", 4'b0100, T_NONSEQ, '1, '0);
      step("s2_wait1", '0, T_IDLE, 4'b1011, '0);
      step("s2_wait2", '0, T_IDLE, 4'b1011, '0);
      step("s2_done", '0, T_IDLE, '1, '0);
      step("s2_after", '0, T_IDLE, '1, '0);

      // 3. unmapped then multi-selected, back to back
      step("unm_addr", '0, T_NONSEQ, '1, '0);
      step("unm_err1", 4'b0011, T_NONSEQ, '1, '0);
      step("unm_err2", 4'b0011, T_NONSEQ, '1, '0);
      step("multi_err1", '0, T_IDLE, '1, '0);
      step("multi_err2", '0, T_IDLE, '1, '0);
      step("unm_okay", '0, T_IDLE, '1, '0);

      // 3b. unmapped followed by a mapped transfer
      step("um_addr", '0, T_NONSEQ, '1, '0);
      step("um_err1", 4'b0010, T_NONSEQ, '1, '0);
      step("um_err2", 4'b0010, T_NONSEQ, '1, '0);
      step("um_mapped", '0, T_IDLE, '1, '0);

      // 4. pipelined slave 0 then slave 3 during slave 0's wait state
      step("pl_addr0", 4'b0001, T_NONSEQ, '1, '0);
      step("pl_wait0", 4'b1000, T_NONSEQ, 4'b1110, '0);
      step("pl_done0", 4'b1000, T_NONSEQ, '1, '0);
      step("pl_data3", '0, T_IDLE, '1, '0);

      // 5. slave 1 two-cycle ERROR passes through
      step("e1_addr", 4'b0010, T_NONSEQ, '1, '0);
      step("e1_cyc1", '0, T_IDLE, 4'b1101, 4'b0010);
      step("e1_cyc2", '0, T_IDLE, '1, 4'b0010);
      step("e1_after", '0, T_IDLE, '1, '0);

      // 6. long stall on slave 0 (timeout when enabled, plain wait otherwise)
      step("st_addr", 4'b0001, T_NONSEQ, '1, '0);
      for (int k = 0; k < TO + 3; k++) step("st_cyc", '0, T_IDLE, 4'b1110, '0);
      step("st_after", '0, T_IDLE, '1, '0);

      // 6b. reset asserted while slave 0 is stalling
      step("rs_addr", 4'b0001, T_NONSEQ, '1, '0);
      step("rs_wait1", '0, T_IDLE, 4'b1110, '0);
      step("rs_wait2", '0, T_IDLE, 4'b1110, '0);
      reset_mid_cycle("reset_mid");
      step("rs_after", '0, T_IDLE, 4'b1110, '0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)      rsel = NS'(1) << $urandom_range(0, NS - 1);
         else if (r < 8) rsel = '0;
         else            rsel = NS'($urandom);
         for (int i = 0; i < NS; i++) begin
            rrdy[i] = ($urandom_range(0, 3) != 0);
            rrsp[i] = ($urandom_range(0, 7) == 0);
            HRDATA_S[i*DW +: DW] = $urandom;
         end
         step("rand", rsel, 2'($urandom), rrdy, rrsp);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/ahb_lite_resp_mux.md
Name: ahb_lite_resp_mux

Overview:
- Parametrised AHB-Lite slave-to-master response multiplexer for NUM_SLAVES slaves, with configurable data width.
- Sits between the address decoder/slaves and the master. Drives HRDATA/HREADY/HRESP to the master and feeds HREADY back to all slaves.
- Registers the address-phase select so the data phase is routed correctly.
- Contains a built-in default slave that returns a two-cycle ERROR for unmapped or multi-selected transfers.

Parameters:
- NUM_SLAVES, 4: number of slave ports, 1..16.
- DATA_WIDTH, 32: HRDATA width, 32 or 64.
- TIMEOUT_CYCLES, 255: wait-state limit before a forced ERROR; used only with the optional feature; range 2..65535.

Ports:
- HCLK  input  1  bus clock; all registers on rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSEL  input  NUM_SLAVES  one-hot slave selects from decoder (address phase).
- HTRANS  input  2  master transfer type (address phase).
- HRDATA_S  input  NUM_SLAVES*DATA_WIDTH  flattened slave read data; slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_S  input  NUM_SLAVES  per-slave HREADYOUT.
- HRESP_S  input  NUM_SLAVES  per-slave HRESP (1 = ERROR).
- HRDATA  output  DATA_WIDTH  read data to master.
- HREADY  output  1  transfer-done to master; also fed back to slaves.
- HRESP  output  1  response to master.
- TIMEOUT  output  1  one-cycle pulse when a forced timeout ERROR starts; tied 0 without the optional feature.

Behaviour:
- Reset (HRESETn = 0, asynchronous): sel_q = 0, def_q = 0, default FSM = IDLE, counter = 0. Outputs: HREADY = 1, HRESP = 0, HRDATA = 0.
- Capture: on a rising HCLK with HREADY = 1 (the mux's own output), the address phase is captured into the data-phase registers:
  - Active transfer (HTRANS[1] = 1) with exactly one HSEL bit set: sel_q <= HSEL, def_q <= 0.
  - Active transfer with HSEL = 0 or more than one bit set: sel_q <= 0, def_q <= 1 (default slave).
  - IDLE/BUSY (HTRANS[1] = 0): sel_q <= 0, def_q <= 0 (no data phase).
- Hold: with HREADY = 0, sel_q, def_q and the FSM data-phase state hold.
- Routing is combinational, zero added latency:
  - sel_q bit i set: HRDATA = slave i data, HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
  - Slave two-cycle ERROR responses pass through unmodified.
- No data phase (sel_q = 0, def_q = 0): HREADY = 1, HRESP = 0, HRDATA = 0.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE -> ERR1 when a capture sets def_q.
  - ERR1: HREADY = 0, HRESP = 1. Always -> ERR2 next cycle.
  - ERR2: HREADY = 1, HRESP = 1, HRDATA = 0. The next address phase is captured in this cycle; -> ERR1 if def_q is set again, else -> IDLE.
- Back-to-back unmapped transfers therefore produce a repeating ERR1, ERR2 pattern with no OKAY cycle between them.
- Sequence "unmapped, then mapped": after ERR2, routing switches to the mapped slave in the next cycle.
- Reset mid-transfer: everything returns to reset values immediately; the slave's pending response is ignored.
- NUM_SLAVES = 1: HSEL is 1 bit; the multi-hot check is vacuous.

Optional Feature:
- Macro: AHB_RESP_MUX_TIMEOUT_EN.
- With macro: a 16-bit wait counter.
  - Clears on every capture.
  - Increments each cycle a routed slave drives HREADYOUT_S[i] = 0.
  - When the counter reaches TIMEOUT_CYCLES, the mux stops routing that slave, pulses TIMEOUT for 1 cycle, and runs ERR1 then ERR2 from the default FSM. The master sees HRESP = 1 / HREADY = 0, then HRESP = 1 / HREADY = 1.
  - Later slave HREADYOUT/HRESP for that transfer is ignored. The next capture happens in ERR2.
  - An active default-slave sequence never counts toward the timeout.
- Without macro: no counter logic; TIMEOUT = 0; slaves may stall indefinitely.

Test Plan:
1. Reset, then release; no transfers -> HREADY = 1, HRESP = 0, HRDATA = 0, TIMEOUT = 0.
2. NONSEQ with HSEL = 4'b0100; slave 2 gives 2 wait states, then HRDATA_S[2] = 32'hDEADBEEF -> HREADY low for 2 cycles, then HREADY = 1 with HRDATA = 32'hDEADBEEF and HRESP = 0. Other slaves' data never appears.
3. NONSEQ with HSEL = 0, then NONSEQ with HSEL = 4'b0011, then IDLE -> ERR1, ERR2, ERR1, ERR2, then HREADY = 1 / HRESP = 0.
4. Pipelined: NONSEQ to slave 0, then slave 3 during slave 0's wait state -> slave 0's data completes first; slave 3 is routed in the following cycle. sel_q holds during the wait.
5. Slave 1 gives a two-cycle ERROR (HRESP_S[1] = 1 with HREADYOUT low, then high) -> identical response at the master outputs.
6. With AHB_RESP_MUX_TIMEOUT_EN and TIMEOUT_CYCLES = 4; slave 0 holds HREADYOUT = 0 -> after 4 wait cycles, TIMEOUT pulses, then ERR1, ERR2. Assert HRESETn during a wait -> outputs return to reset values asynchronously.
